radix4_seq_multiplier: RTL and testbench

//  Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, radix-4 (2 multiplier bits per cycle).

---
 rtl/radix4_seq_multiplier_if.sv | 30 +++
 rtl/radix4_seq_multiplier.sv | 121 ++++++++++++
 tb/tb_radix4_seq_multiplier.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/radix4_seq_multiplier_if.sv
`timescale 1ns/1ps
// Operand/result bundle between the factorial core (master) and the
// radix-4 sequential multiplier (slave).
//   multiplier, multiplicand : operands, sampled on the start edge
//   op_start                 : start request, level
//   op_clear                 : abort/rearm, synchronous
//   op_done                  : result valid
//   busy                     : operation in progress
//   result                   : 2*WIDTH-bit product, 0 unless op_done
interface radix4_seq_multiplier_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplicand;
  logic               op_start;
  logic               op_clear;
  logic               op_done;
  logic               busy;
  logic [2*WIDTH-1:0] result;

  modport master (
    output multiplier, multiplicand, op_start, op_clear,
    input  op_done, busy, result
  );

  modport slave (
    input  multiplier, multiplicand, op_start, op_clear,
    output op_done, busy, result
  );
endinterface

// File: rtl/radix4_seq_multiplier.sv
`timescale 1ns/1ps
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, two multiplier
// bits retired per cycle, fixed latency of WIDTH/2 cycles.
// Ports:
//   clk     : clock, rising edge
//   reset_n : synchronous reset, active-low
//   mul_s   : operand/handshake/result bundle (slave side)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for op_start; operands latched on the start edge
// BUSY  | shift-add in progress, one radix-4 digit per cycle
// DONE  | product held on result, op_done high until op_clear
module radix4_seq_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  radix4_seq_multiplier_if.slave mul_s
);
  localparam int              CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH+1:0] m3_q, m3_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH+2:0] addend;
  logic [WIDTH+2:0] sum;

  // State register; op_clear outranks every transition, including DONE entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else if (mul_s.op_clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mul_s.op_start)  state_d = ST_BUSY;
      ST_BUSY: if (count_q == LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mul_s.busy    = (state_q == ST_BUSY);
    mul_s.op_done = (state_q == ST_DONE);
    mul_s.result  = (state_q == ST_DONE) ? {acc_q[WIDTH-1:0], q_q} : '0;
  end

  // Radix-4 digit selects 0, M, 2M or the precomputed 3M.
  always_comb begin
    addend = '0;
    unique case (q_q[1:0])
      2'd0: addend = '0;
      2'd1: addend = {3'b000, m_q};
      2'd2: addend = {2'b00, m_q, 1'b0};
      2'd3: addend = {1'b0, m3_q};
      default: addend = '0;
    endcase
    sum = {1'b0, acc_q} + addend;
  end

  always_comb begin
    m_d     = m_q;
    m3_d    = m3_q;
    q_d     = q_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mul_s.op_start) begin
          m_d     = mul_s.multiplicand;
          m3_d    = {2'b00, mul_s.multiplicand} + {1'b0, mul_s.multiplicand, 1'b0};
          q_d     = mul_s.multiplier;
          acc_d   = '0;
          count_d = '0;
        end
      end
      ST_BUSY: begin
        // {ACC,Q} <= {sum,Q} >> 2: low sum bits shift into the top of Q.
        acc_d   = sum[WIDTH+2:2];
        q_d     = {sum[1:0], q_q[WIDTH-1:2]};
        count_d = count_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || mul_s.op_clear) begin
      m_q     <= '0;
      m3_q    <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      m_q     <= m_d;
      m3_q    <= m3_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_radix4_seq_multiplier.sv
`timescale 1ns/1ps
module tb_radix4_seq_multiplier;
  localparam int W   = 64;
  localparam int LAT = W / 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  radix4_seq_multiplier_if #(.WIDTH(W)) bus ();

  radix4_seq_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .mul_s  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after the start edge; counts edges until op_done, bounded.
  task automatic wait_done(output int lat);
    int bad;
    bad = 0;
    lat = 0;
    while (bus.op_done !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1) bad++;
      tick();
      lat++;
    end
    if (bus.busy !== 1'b0) bad++;
    chk("busy_profile", bad, 0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] res, output int lat);
    bus.multiplier   = a;
    bus.multiplicand = b;
    bus.op_start     = 1'b1;
    tick();
    wait_done(lat);
    res = bus.result;
  endtask

  task automatic clear_op();
    bus.op_start = 1'b0;
    bus.op_clear = 1'b1;
    tick();
    bus.op_clear = 1'b0;
    chk("clear_done", bus.op_done, 0);
    chk("clear_busy", bus.busy, 0);
    chk("clear_result", bus.result, 0);
  endtask

  initial begin
    logic [2*W-1:0] res;
    logic [W-1:0]   ra, rb;
    int             lat;

    checks = 0;
    errors = 0;

    vecs[0] = '{64'd3, 64'd5, 128'h0F};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[2] = '{64'd0, 64'h1234_5678_9ABC_DEF0, 128'h0};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'd0, 128'h0};
    vecs[4] = '{64'd1, 64'd1, 128'h1};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'hFFFF_FFFF_FFFF_FFFF};
    vecs[7] = '{64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000};
    vecs[8] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 128'h1_FFFF_FFFF_FFFF_FFFE};
    vecs[9] = '{64'd12345, 64'd100, 128'd1234500};

    reset_n          = 1'b0;
    bus.multiplier   = '0;
    bus.multiplicand = '0;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    tick();
    tick();
    chk("reset_done", bus.op_done, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_result", bus.result, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_busy", bus.busy, 0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].p);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
      clear_op();
    end

    // 3 x 5 with op_start held: result and op_done stay put, no retrigger
    do_op(64'd3, 64'd5, res, lat);
    chk("hold_latency", lat, LAT);
    repeat (20) tick();
    chk("hold_done", bus.op_done, 1);
    chk("hold_busy", bus.busy, 0);
    chk("hold_result", bus.result, 128'h0F);
    clear_op();

    // Inputs changed mid-operation have no effect
    bus.multiplier   = 64'd7;
    bus.multiplicand = 64'd9;
    bus.op_start     = 1'b1;
    tick();
    bus.op_start = 1'b0;
    repeat (5) tick();
    bus.multiplier   = '0;
    bus.multiplicand = '0;
    wait_done(lat);
    chk("change_latency", lat + 5, LAT);
    chk("change_result", bus.result, 128'd63);
    clear_op();
    do_op(64'd2, 64'd3, res, lat);
    chk("rearm_result", res, 128'd6);
    chk("rearm_latency", lat, LAT);
    clear_op();

    // op_clear mid-BUSY with op_start held, restart after clear drops
    bus.multiplier   = 64'd11;
    bus.multiplicand = 64'd13;
    bus.op_start     = 1'b1;
    tick();
    repeat (10) tick();
    bus.op_clear = 1'b1;
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.op_done, 0);
    bus.op_clear     = 1'b0;
    bus.multiplier   = 64'd4;
    bus.multiplicand = 64'd5;
    tick();
    wait_done(lat);
    chk("restart_latency", lat, LAT);
    chk("restart_result", bus.result, 128'd20);
    clear_op();

    // reset_n low mid-BUSY discards the operation
    bus.multiplier   = 64'd9;
    bus.multiplicand = 64'd9;
    bus.op_start     = 1'b1;
    tick();
    repeat (10) tick();
    reset_n      = 1'b0;
    bus.op_start = 1'b0;
    tick();
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.op_done, 0);
    chk("rst_mid_result", bus.result, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rst_after_busy", bus.busy, 0);
    chk("rst_after_done", bus.op_done, 0);

    // op_clear on the DONE-entry edge wins
    bus.multiplier   = 64'd6;
    bus.multiplicand = 64'd7;
    bus.op_start     = 1'b1;
    tick();
    bus.op_start = 1'b0;
    repeat (LAT - 1) tick();
    chk("pre_done_busy", bus.busy, 1);
    bus.op_clear = 1'b1;
    tick();
    bus.op_clear = 1'b0;
    chk("race_done", bus.op_done, 0);
    chk("race_busy", bus.busy, 0);
    chk("race_result", bus.result, 0);
    repeat (3) tick();
    chk("race_stays_idle", bus.op_done, 0);

    // Random sweep against plain 128-bit arithmetic
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 10 == 1) ra = ra >> $urandom_range(63, 0);
      if (n % 10 == 2) rb = rb >> $urandom_range(63, 0);
      do_op(ra, rb, res, lat);
      chk("rand_result", res, {{W{1'b0}}, ra} * {{W{1'b0}}, rb});
      chk("rand_latency", lat, LAT);
      clear_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
